// File: rtl/i2c_slave_rx_if.sv
// Bus-side signal bundle for the receive-only I2C slave: raw SCL/SDA in, ACK drive and
// byte/event reporting out.
interface i2c_slave_rx_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       start_det;
  logic       stop_det;

  modport slave (
    input  scl, sda_in,
    output sda_oe, rx_data, rx_valid, busy, start_det, stop_det
  );

  modport master (
    output scl, sda_in,
    input  sda_oe, rx_data, rx_valid, busy, start_det, stop_det
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: synchronizes the raw bus, decodes START/STOP/SCL edges, matches a
// 7-bit address, ACKs address and data bytes and reports each received byte.
module i2c_slave_rx #(
  parameter logic [6:0] SLV_ADDR = 7'h2A
) (
  input  logic              clk,
  input  logic              reset,
  i2c_slave_rx_if.slave     bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] DATA_ACK = 3'd4;

  logic       scl_m_q, scl_m_d, scl_s_q, scl_s_d, scl_p_q, scl_p_d;
  logic       sda_m_q, sda_m_d, sda_s_q, sda_s_d, sda_p_q, sda_p_d;
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev, addr_match;
  logic [7:0] shift_in;

  assign scl_rise   = ~scl_p_q &  scl_s_q;
  assign scl_fall   =  scl_p_q & ~scl_s_q;
  assign start_ev   =  scl_p_q &  scl_s_q &  sda_p_q & ~sda_s_q;
  assign stop_ev    =  scl_p_q &  scl_s_q & ~sda_p_q &  sda_s_q;
  assign shift_in   = {shift_q[6:0], sda_s_q};
  assign addr_match = (shift_q == {SLV_ADDR, 1'b0});

  always_comb begin
    scl_m_d     = bus.scl;
    scl_s_d     = scl_m_q;
    scl_p_d     = scl_s_q;
    sda_m_d     = bus.sda_in;
    sda_s_d     = sda_m_q;
    sda_p_d     = sda_s_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    start_det_d = start_ev;
    stop_det_d  = stop_ev;

    // Bus conditions override whatever byte handling is in progress.
    if (start_ev) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      shift_d  = 8'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_ev) begin
      if (state_q != IDLE) begin
        state_d  = IDLE;
        cnt_d    = 4'd0;
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (addr_match) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // The fall that entered this state was already consumed, so this is the 9th fall.
          if (scl_fall) begin
            state_d  = DATA;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
          end
        end
        DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d  = DATA_ACK;
            sda_oe_d = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_m_q     <= 1'b1;
      scl_s_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_m_q     <= 1'b1;
      sda_s_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      scl_m_q     <= scl_m_d;
      scl_s_q     <= scl_s_d;
      scl_p_q     <= scl_p_d;
      sda_m_q     <= sda_m_d;
      sda_s_q     <= sda_s_d;
      sda_p_q     <= sda_p_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      sda_oe_q    <= sda_oe_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;

endmodule
